// File: rtl/move_serializer_pkg.sv
// rtl/move_serializer_pkg.sv - shared piece encodings, FSM states and piece-value table
package move_serializer_pkg;

  localparam int PIECE_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DONE
  } state_e;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic [2:0] FILE_A = 3'd0;
  localparam logic [2:0] FILE_B = 3'd1;
  localparam logic [2:0] FILE_C = 3'd2;
  localparam logic [2:0] FILE_D = 3'd3;
  localparam logic [2:0] FILE_E = 3'd4;
  localparam logic [2:0] FILE_F = 3'd5;
  localparam logic [2:0] FILE_G = 3'd6;
  localparam logic [2:0] FILE_H = 3'd7;

  localparam logic [2:0] RANK_ONE   = 3'd0;
  localparam logic [2:0] RANK_TWO   = 3'd1;
  localparam logic [2:0] RANK_THREE = 3'd2;
  localparam logic [2:0] RANK_FOUR  = 3'd3;
  localparam logic [2:0] RANK_FIVE  = 3'd4;
  localparam logic [2:0] RANK_SIX   = 3'd5;
  localparam logic [2:0] RANK_SEVEN = 3'd6;
  localparam logic [2:0] RANK_EIGHT = 3'd7;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  function automatic logic [3:0] piece_value_lut(input logic [2:0] ptype);
    case (ptype)
      PAWN:    piece_value_lut = 4'd1;
      KNIGHT:  piece_value_lut = 4'd3;
      BISHOP:  piece_value_lut = 4'd3;
      ROOK:    piece_value_lut = 4'd5;
      QUEEN:   piece_value_lut = 4'd9;
      KING:    piece_value_lut = 4'd15;
      default: piece_value_lut = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/piece_value.sv
// rtl/piece_value.sv - combinational material value of a piece type
module piece_value
  import move_serializer_pkg::*;
(
  input  logic [2:0] ptype_i,
  output logic [3:0] value_o
);

  always_comb begin
    value_o = piece_value_lut(ptype_i);
  end

endmodule

// File: rtl/move_serializer.sv
// rtl/move_serializer.sv - latches a set of candidate moves and emits the legal ones one per cycle
module move_serializer
  import move_serializer_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SLOTS*SLOT_W-1:0] move,
  input  logic [NUM_SLOTS-1:0]        move_valid,
  input  logic                        move_load,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [SLOT_W-1:0]           out_move,
  output logic                        out_capture,
  output logic [3:0]                  out_value,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  move_count
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    slots_q [NUM_SLOTS];
  logic [SLOT_W-1:0]    slots_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [NUM_SLOTS-1:0] load_mask;
  logic [3:0]           count_q, count_d;
  logic [IDX_W-1:0]     sel_idx;

  // A move onto an occupied square of the mover's own colour is never legal.
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load_mask[i] = move_valid[i] &&
                     !((move[i*SLOT_W+7 +: 3] != EMPTY) &&
                       (move[i*SLOT_W] == move[i*SLOT_W+PIECE_W]));
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    out_valid   = (state_q == ST_EMIT);
    out_move    = out_valid ? slots_q[sel_idx] : '0;
    out_capture = (out_move[9:7] != EMPTY) && (out_move[0] != out_move[PIECE_W]);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    move_count  = count_q;
  end

  piece_value u_piece_value (
    .ptype_i (out_move[9:7]),
    .value_o (out_value)
  );

  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (move_load) begin
          for (int i = 0; i < NUM_SLOTS; i++) slots_d[i] = move[i*SLOT_W +: SLOT_W];
          pending_d = load_mask;
          count_d   = '0;
          state_d   = (|load_mask) ? ST_EMIT : ST_DONE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          pending_d[sel_idx] = 1'b0;
          count_d            = count_q + 4'd1;
          if (pending_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      slots_q   <= slots_d;
    end
  end

endmodule
